// File: rtl/cpu_sram_arbiter_if.sv
// cpu_sram_arbiter_if: one sram-like port; request fields flow master->slave, ok/rdata slave->master.
interface cpu_sram_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: merges inst/data sram-like masters onto one slave port, routing
// in-order responses back through a tag FIFO of outstanding requests.
module cpu_sram_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input logic                  clk,
    input logic                  resetn,
    cpu_sram_arbiter_if.slave    inst,
    cpu_sram_arbiter_if.slave    data,
    cpu_sram_arbiter_if.master   mem
);
    localparam int AW = $clog2(OUTSTANDING);

    logic [AW:0]             r_count;
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [OUTSTANDING-1:0]  r_tag;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_sel_data;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_head;

    assign w_full     = r_count == (AW+1)'(OUTSTANDING);
    assign w_empty    = r_count == '0;
    assign w_sel_data = data.req;
    assign w_head     = r_tag[r_rptr];
    assign w_push     = mem.req & mem.addr_ok;
    assign w_pop      = mem.data_ok & ~w_empty;

    always_comb begin
        mem.req   = (inst.req | data.req) & ~w_full;
        mem.wr    = w_sel_data ? data.wr : 1'b0;
        mem.size  = w_sel_data ? data.size : inst.req ? 2'd2 : 2'd0;
        mem.addr  = w_sel_data ? data.addr : inst.req ? inst.addr : 32'd0;
        mem.wdata = w_sel_data ? data.wdata : 32'd0;
    end

    assign data.addr_ok = w_push & w_sel_data;
    assign inst.addr_ok = w_push & ~w_sel_data;
    assign inst.data_ok = w_pop & ~w_head;
    assign data.data_ok = w_pop & w_head;
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_tag   <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wptr] <= w_sel_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

`ifndef SYNTHESIS
    // A response with nothing in flight (e.g. one left over from before reset) is dropped.
    always_ff @(posedge clk)
        if (resetn && mem.data_ok)
            assert (!w_empty) else $warning("spurious mem data_ok ignored");
`endif
endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb_cpu_sram_arbiter: directed scenarios plus randomized traffic against a queue-based
// model of in-order responses.
module tb_cpu_sram_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    cpu_sram_arbiter_if ii ();
    cpu_sram_arbiter_if di ();
    cpu_sram_arbiter_if mi ();

    cpu_sram_arbiter #(.OUTSTANDING(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .inst   (ii),
        .data   (di),
        .mem    (mi)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [1:0] ds, input logic [31:0] da, input logic [31:0] dd,
                         input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        ii.req = ir; ii.addr = ia; ii.wr = 1'b0; ii.size = 2'd2; ii.wdata = 32'd0;
        di.req = dr; di.wr = dw; di.size = ds; di.addr = da; di.wdata = dd;
        mi.addr_ok = aok; mi.data_ok = dok; mi.rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD0000 + i);
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if ({ii.addr_ok, di.addr_ok, ii.data_ok, di.data_ok, mi.req} !== 5'b0) begin
            fails++; $display("FAIL reset_oks got %b exp 00000", {ii.addr_ok, di.addr_ok, ii.data_ok, di.data_ok, mi.req});
        end
        tests++;
        if (int'(dut.r_count) != 0) begin fails++; $display("FAIL reset_count got %0d exp 0", dut.r_count); end
        tests++;
        if ({mi.addr, mi.wdata, mi.size, mi.wr} !== 67'd0) begin
            fails++; $display("FAIL reset_mem_fields got %h/%h/%0d/%b exp zeros", mi.addr, mi.wdata, mi.size, mi.wr);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_inst_fetch();
        drive(1, 32'hBFC00000, 0, 0, 0, 0, 0, 1, 0, 0);
        tests++;
        if (ii.addr_ok !== 1'b1 || mi.req !== 1'b1 || mi.addr !== 32'hBFC00000 || mi.size !== 2'd2 || mi.wr !== 1'b0) begin
            fails++; $display("FAIL fetch_req got ok=%b req=%b addr=%h size=%0d wr=%b exp 1 1 bfc00000 2 0", ii.addr_ok, mi.req, mi.addr, mi.size, mi.wr);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3C010000);
        tests++;
        if (ii.data_ok !== 1'b1 || ii.rdata !== 32'h3C010000 || di.data_ok !== 1'b0) begin
            fails++; $display("FAIL fetch_resp got iok=%b rdata=%h dok=%b exp 1 3c010000 0", ii.data_ok, ii.rdata, di.data_ok);
        end
        tick();
    endtask

    task automatic test_priority();
        drive(1, 32'hBFC00004, 1, 1, 2, 32'h80001000, 32'h12345678, 1, 0, 0);
        tests++;
        if (mi.addr !== 32'h80001000 || mi.wr !== 1'b1 || mi.wdata !== 32'h12345678 || ii.addr_ok !== 1'b0 || di.addr_ok !== 1'b1) begin
            fails++; $display("FAIL prio_c0 got addr=%h wr=%b wdata=%h iok=%b dok=%b exp 80001000 1 12345678 0 1", mi.addr, mi.wr, mi.wdata, ii.addr_ok, di.addr_ok);
        end
        tick();
        drive(1, 32'hBFC00004, 0, 0, 0, 0, 0, 1, 0, 0);
        tests++;
        if (mi.addr !== 32'hBFC00004 || mi.wr !== 1'b0 || mi.wdata !== 32'd0 || ii.addr_ok !== 1'b1) begin
            fails++; $display("FAIL prio_c1 got addr=%h wr=%b wdata=%h iok=%b exp bfc00004 0 0 1", mi.addr, mi.wr, mi.wdata, ii.addr_ok);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111);
        tests++;
        if (di.data_ok !== 1'b1 || ii.data_ok !== 1'b0) begin
            fails++; $display("FAIL prio_resp0 got d=%b i=%b exp 1 0", di.data_ok, ii.data_ok);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222);
        tests++;
        if (ii.data_ok !== 1'b1 || di.data_ok !== 1'b0) begin
            fails++; $display("FAIL prio_resp1 got i=%b d=%b exp 1 0", ii.data_ok, di.data_ok);
        end
        tick();
    endtask

    task automatic test_ordering();
        drive(1, 32'hBFC00010, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 1, 0, 2, 32'h80002000, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0000);
        tests++;
        if (ii.data_ok !== 1'b1 || di.data_ok !== 1'b0 || ii.rdata !== 32'hAAAA0000) begin
            fails++; $display("FAIL order_first got i=%b d=%b rdata=%h exp 1 0 aaaa0000", ii.data_ok, di.data_ok, ii.rdata);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555FFFF);
        tests++;
        if (di.data_ok !== 1'b1 || ii.data_ok !== 1'b0 || di.rdata !== 32'h5555FFFF) begin
            fails++; $display("FAIL order_second got d=%b i=%b rdata=%h exp 1 0 5555ffff", di.data_ok, ii.data_ok, di.rdata);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 2, 32'h80003000 + 4 * i, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0, 2, 32'h80003010, 0, 1, 0, 0);
        tests++;
        if (mi.req !== 1'b0 || di.addr_ok !== 1'b0 || int'(dut.r_count) != 4) begin
            fails++; $display("FAIL full_gate got req=%b ok=%b count=%0d exp 0 0 4", mi.req, di.addr_ok, dut.r_count);
        end
        tick();
        drive(0, 0, 1, 0, 2, 32'h80003010, 0, 1, 1, 32'h0BADF00D);
        tests++;
        if (mi.req !== 1'b0 || di.data_ok !== 1'b1) begin
            fails++; $display("FAIL full_pop_same_cycle got req=%b dok=%b exp 0 1", mi.req, di.data_ok);
        end
        tick();
        drive(0, 0, 1, 0, 2, 32'h80003010, 0, 1, 0, 0);
        tests++;
        if (mi.req !== 1'b1 || di.addr_ok !== 1'b1) begin
            fails++; $display("FAIL full_release got req=%b ok=%b exp 1 1", mi.req, di.addr_ok);
        end
        tick();
        drain(2);
        drive(0, 0, 1, 0, 2, 32'h80003020, 0, 1, 1, 32'h12121212);
        tick();
        #1;
        tests++;
        if (int'(dut.r_count) != 2) begin fails++; $display("FAIL push_pop_count got %0d exp 2", dut.r_count); end
        drain(2);
    endtask

    task automatic test_reset_midflight();
        drive(1, 32'hBFC00020, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 32'hBFC00024, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        #1;
        tests++;
        if (int'(dut.r_count) != 0) begin fails++; $display("FAIL rst_async_count got %0d exp 0", dut.r_count); end
        #1 resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEBABE);
        tests++;
        if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin
            fails++; $display("FAIL rst_late_resp got i=%b d=%b exp 0 0", ii.data_ok, di.data_ok);
        end
        tick();
        #1;
        tests++;
        if (int'(dut.r_count) != 0) begin fails++; $display("FAIL rst_late_count got %0d exp 0", dut.r_count); end
    endtask

    task automatic test_spurious();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77777777);
        tests++;
        if (ii.data_ok !== 1'b0 || di.data_ok !== 1'b0) begin
            fails++; $display("FAIL spurious_ok got i=%b d=%b exp 0 0", ii.data_ok, di.data_ok);
        end
        tick();
        #1;
        tests++;
        if (int'(dut.r_count) != 0) begin fails++; $display("FAIL spurious_count got %0d exp 0", dut.r_count); end
    endtask

    task automatic test_random();
        logic        mq[$];
        logic        ir = 0, dr = 0, dw = 0, aok, dok, full, er;
        logic [1:0]  ds = 0;
        logic [31:0] ia = 0, da = 0, dd = 0, rd, ea;
        for (int n = 0; n < 400; n++) begin
            if (!ir) begin ir = 1'($urandom_range(0, 1)); ia = $urandom & 32'hFFFF_FFFC; end
            if (!dr) begin
                dr = 1'($urandom_range(0, 2) == 0); dw = 1'($urandom_range(0, 1));
                ds = 2'($urandom_range(0, 2)); da = $urandom; dd = $urandom;
            end
            aok = 1'($urandom_range(0, 3) != 0);
            dok = mq.size() > 0 && $urandom_range(0, 2) != 0;
            rd  = $urandom;
            drive(ir, ia, dr, dw, ds, da, dd, aok, dok, rd);
            full = mq.size() == 4;
            er   = (ir | dr) && !full;
            ea   = dr ? da : ir ? ia : 32'd0;
            tests++;
            if (mi.req !== er || mi.addr !== ea || mi.wr !== (dr && dw)) begin
                fails++; $display("FAIL rnd_req n=%0d got req=%b addr=%h wr=%b exp %b %h %b", n, mi.req, mi.addr, mi.wr, er, ea, dr && dw);
            end
            tests++;
            if (ii.addr_ok !== (er && aok && !dr) || di.addr_ok !== (er && aok && dr)) begin
                fails++; $display("FAIL rnd_addr_ok n=%0d got i=%b d=%b exp %b %b", n, ii.addr_ok, di.addr_ok, er && aok && !dr, er && aok && dr);
            end
            tests++;
            if (ii.data_ok !== (dok && !mq[0]) || di.data_ok !== (dok && mq[0]) || di.rdata !== rd || ii.rdata !== rd) begin
                fails++; $display("FAIL rnd_resp n=%0d got i=%b d=%b rdata=%h exp %b %b %h", n, ii.data_ok, di.data_ok, di.rdata, dok && !mq[0], dok && mq[0], rd);
            end
            if (dok) void'(mq.pop_front());
            if (er && aok) begin
                mq.push_back(dr);
                if (dr) dr = 0; else ir = 0;
            end
            tick();
        end
        drain(mq.size());
    endtask

    initial begin
        test_reset();
        test_inst_fetch();
        test_priority();
        test_ordering();
        test_full();
        test_reset_midflight();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
